// File: rtl/ram2_arbiter.sv
// ram2_arbiter: shares the single-port byte-writable data RAM between two requesters.
//   m0 = core load/store unit, m1 = debug/program loader.
//   At most one access is granted per cycle. The granted request drives the RAM
//   ports, and read data returns to that requester on the following cycle.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mN_req/we/addr/wdata/be         requester N command (N=0,1), held until mN_gnt
//   mN_gnt                          combinational accept, same cycle as mN_req
//   mN_rvalid/rdata                 response pulse the cycle after mN_gnt; rdata = ram_rd_data
//   ram_addr/wr_data/wr_en/wr_byte_en  RAM command for the granted requester
//   ram_rd_data                     RAM read data, 1-cycle latency
module ram2_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 32,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [BE_WIDTH-1:0]   m0_be,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [BE_WIDTH-1:0]   m1_be,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       r_rsp_v;
    logic       r_rsp_id;
    logic       r_last_gnt;
    logic [7:0] r_starve;
    logic       w_pick1;
    logic       w_gnt0;
    logic       w_gnt1;

    // On contention m1 wins when round-robin says it is its turn, or when the
    // fixed-priority starvation guard has run out.
    assign w_pick1 = (ARB_MODE == 0) ? !r_last_gnt : (r_starve == LIMIT);
    assign w_gnt1  = rst_n && m1_req && (!m0_req || w_pick1);
    assign w_gnt0  = rst_n && m0_req && !w_gnt1;

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_rsp_v && !r_rsp_id;
    assign m1_rvalid = r_rsp_v && r_rsp_id;
    assign m0_rdata  = ram_rd_data;
    assign m1_rdata  = ram_rd_data;

    always_comb begin
        ram_addr       = '0;
        ram_wr_data    = '0;
        ram_wr_en      = 1'b0;
        ram_wr_byte_en = '0;
        if (w_gnt1) begin
            ram_addr       = m1_addr;
            ram_wr_data    = m1_wdata;
            ram_wr_en      = m1_we;
            ram_wr_byte_en = m1_be;
        end else if (w_gnt0) begin
            ram_addr       = m0_addr;
            ram_wr_data    = m0_wdata;
            ram_wr_en      = m0_we;
            ram_wr_byte_en = m0_be;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_v    <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_last_gnt <= 1'b1;
            r_starve   <= '0;
        end else begin
            r_rsp_v  <= w_gnt0 || w_gnt1;
            r_rsp_id <= w_gnt1;
            if (w_gnt0 || w_gnt1)
                r_last_gnt <= w_gnt1;
            r_starve <= (!m1_req || w_gnt1) ? '0 :
                        (r_starve == LIMIT) ? r_starve : r_starve + 8'd1;
        end
    end
endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter: directed vector bench for ram2_arbiter with a behavioural RAM.
module tb_ram2_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [12:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [12:0] ram_addr;
    logic [31:0] ram_wr_data, ram_rd_data;
    logic        ram_wr_en;
    logic [3:0]  ram_wr_byte_en;
    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_ram_wr_data;
    logic [12:0] fp_ram_addr;
    logic        fp_ram_wr_en;
    logic [3:0]  fp_ram_wr_byte_en;
    logic [31:0] mem [0:8191];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ram2_arbiter #(.ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data)
    );

    ram2_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .ram_addr(fp_ram_addr), .ram_wr_data(fp_ram_wr_data), .ram_wr_en(fp_ram_wr_en),
        .ram_wr_byte_en(fp_ram_wr_byte_en), .ram_rd_data(ram_rd_data)
    );

    // Behavioural RAM: byte-enabled write, registered read of the old contents.
    always @(posedge clk) begin
        if (ram_wr_en)
            for (int b = 0; b < 4; b++)
                if (ram_wr_byte_en[b])
                    mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
        ram_rd_data <= mem[ram_addr];
    end

    typedef struct {
        logic        rn, r0, w0;
        logic [12:0] a0;
        logic        r1, w1;
        logic [12:0] a1;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        g0, g1, v0, v1, wen, cv, cd;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rn, logic r0, logic w0, logic [12:0] a0,
                                logic r1, logic w1, logic [12:0] a1, logic [31:0] wd,
                                logic [3:0] be, logic g0, logic g1, logic v0, logic v1,
                                logic wen, logic cv, logic cd, logic [31:0] d);
        vec_t v;
        v.rn = rn; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.wd = wd; v.be = be; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.wen = wen; v.cv = cv; v.cd = cd; v.d = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic r0, input logic w0, input logic [12:0] a0,
                         input logic r1, input logic w1, input logic [12:0] a1,
                         input logic [31:0] wd, input logic [3:0] be);
        rst_n = rn; m0_req = r0; m0_we = w0; m0_addr = a0; m1_req = r1; m1_we = w1;
        m1_addr = a1; m0_wdata = wd; m1_wdata = wd; m0_be = be; m1_be = be;
    endtask

    initial begin
        logic [8:0] r1_pat;
        logic [8:0] g1_pat;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        mem[13'h010] = 32'hDEADBEEF;
        mem[13'h020] = 32'hAABBCCDD;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset, gnt forced low while rst_n=0 even with requests
        vecs.push_back(mk(0,0,0,0,    0,0,0,0,0,             0,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,    1,0,1,0,0,             0,0,0,0,0,1,0,0));
        // m0 reads 0x010 alone
        vecs.push_back(mk(1,1,0,'h10, 0,0,0,0,0,             1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,0,             0,0,1,0,0,1,1,32'hDEADBEEF));
        // round-robin from reset, both reading
        vecs.push_back(mk(0,0,0,0,    0,0,0,0,0,             0,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,0,    1,0,1,0,0,             1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,0,    1,0,1,0,0,             0,1,1,0,0,1,1,32'h11111111));
        vecs.push_back(mk(1,1,0,0,    1,0,1,0,0,             1,0,0,1,0,1,1,32'h22222222));
        vecs.push_back(mk(1,1,0,0,    1,0,1,0,0,             0,1,1,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,0,    1,0,1,0,0,             1,0,0,1,0,1,0,0));
        vecs.push_back(mk(1,1,0,0,    1,0,1,0,0,             0,1,1,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,0,             0,0,0,1,0,1,1,32'h22222222));
        // m1 partial write then read-back of the same word
        vecs.push_back(mk(1,0,0,0,    1,1,'h20,32'h12345678,4'b0011, 0,1,0,0,1,1,0,0));
        vecs.push_back(mk(1,0,0,0,    1,0,'h20,0,0,           0,1,0,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,0,             0,0,0,1,0,1,1,32'hAABB5678));
        // m0 read, then reset drops the response and restores m0-first contention
        vecs.push_back(mk(1,1,0,'h10, 0,0,0,0,0,             1,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,    0,0,0,0,0,             0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,'h10, 1,0,1,0,0,             1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,0,             0,0,1,0,0,1,1,32'hDEADBEEF));
        // m0 streams 4 reads back to back
        vecs.push_back(mk(1,1,0,0,    0,0,0,0,0,             1,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,1,    0,0,0,0,0,             1,0,1,0,0,1,1,32'h11111111));
        vecs.push_back(mk(1,1,0,2,    0,0,0,0,0,             1,0,1,0,0,1,1,32'h22222222));
        vecs.push_back(mk(1,1,0,3,    0,0,0,0,0,             1,0,1,0,0,1,1,32'h33333333));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,0,             0,0,1,0,0,1,1,32'h44444444));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,0,             0,0,0,0,0,1,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rn, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].r1, vecs[i].w1,
                  vecs[i].a1, vecs[i].wd, vecs[i].be);
            #1;
            check($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].g0));
            check($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].g1));
            check($sformatf("v%0d ram_wr_en", i), 32'(ram_wr_en), 32'(vecs[i].wen));
            if (vecs[i].cv) begin
                check($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vecs[i].v0));
                check($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vecs[i].v1));
            end
            if (vecs[i].cd)
                check($sformatf("v%0d rdata", i), vecs[i].v0 ? m0_rdata : m1_rdata, vecs[i].d);
        end

        // fixed priority with starvation guard; round-robin ram_addr alongside
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 5, 1, 0, 7, 0, 0);
            #1;
            check($sformatf("fp%0d m1_gnt", i), 32'(fp_m1_gnt), 32'(i == 4 || i == 9));
            check($sformatf("fp%0d m0_gnt", i), 32'(fp_m0_gnt), 32'(!(i == 4 || i == 9)));
            check($sformatf("rr%0d ram_addr", i), 32'(ram_addr), (i % 2) ? 32'd7 : 32'd5);
        end
        // dropping m1_req clears the starvation count
        r1_pat = 9'b111110111;
        g1_pat = 9'b100000000;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 5, r1_pat[i], 0, 7, 0, 0);
            #1;
            check($sformatf("fpc%0d m1_gnt", i), 32'(fp_m1_gnt), 32'(g1_pat[i]));
            check($sformatf("fpc%0d m0_gnt", i), 32'(fp_m0_gnt), 32'(!g1_pat[i]));
        end

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
